// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Holds the FSM state encoding, the default bit period and the 8N1 frame
// constants, plus a helper that sizes the bit timer counter.
package fifo_uart_pkg;

  // 50 MHz system clock, 115200 baud.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  // 8N1 frame layout.
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  // Index over the data bits of one frame.
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  // Counter width able to hold 0 .. clks-1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned clks);
    int unsigned w;
    w = $clog2(clks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts 0 .. CLKS_PER_BIT-1 and pulses tick on the terminal count, then
// wraps to 0 so consecutive bits follow without a gap.
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   clear  hold the counter at 0 (used while no bit is on the line)
//   tick   high during the last cycle of each bit period
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TMR_W = timer_width(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TERMINAL = TMR_W'(CLKS_PER_BIT - 1);

  logic [TMR_W-1:0] count;

  // Free-running bit counter, restarted by clear or at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + TMR_W'(1);
    end
  end

  assign tick = (count == TERMINAL);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter.
// Pops one byte from the upstream FIFO whenever it is non-empty and the
// line is idle, then shifts it out LSB first framed by a start and a stop
// bit. Reports busy, a per-frame completion pulse and a wrapping count of
// completed frames.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   FIFO read strobe, one pulse per byte
//   tx           serial line, idle high, registered
//   busy         high whenever the FSM is not idle
//   frame_done   pulse in the last cycle of each stop bit
//   frames_sent  completed frame count, wraps modulo 2**CNT_W
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   shift_next;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [BIT_IDX_W-1:0]   bit_idx_next;
  logic                   tx_next;
  logic                   tick;
  logic                   timer_clear;

  // The timer only runs while a bit is on the line, so every START begins
  // from a clean count after LATCH.
  assign timer_clear = !(state inside {ST_START, ST_DATA, ST_STOP});

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_POP;
        end
      end
      // Empty was already seen low in IDLE; no re-check here.
      ST_POP: begin
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        shift_next   = fifo_data;
        bit_idx_next = '0;
        state_next   = ST_START;
      end
      ST_START: begin
        if (tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + BIT_IDX_W'(1);
          if (bit_idx == LAST_BIT) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode; tx is computed from the next state so the line changes
  // on the same edge the FSM enters a new bit.
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    tx_next    = 1'b1;
    case (state)
      ST_IDLE: busy       = 1'b0;
      ST_POP:  fifo_rd_en = 1'b1;
      ST_STOP: frame_done = tick;
      default: ;
    endcase
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  // Shift register, bit index, serial line and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift       <= '0;
      bit_idx     <= '0;
      tx          <= 1'b1;
      frames_sent <= '0;
    end else begin
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      if (frame_done) begin
        frames_sent <= frames_sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a 4-clock bit period and a
// 2-bit frame counter. A queue stands in for the FIFO; expected line,
// strobe and counter traces are derived from frame arithmetic
// (2 lead-in cycles, 10 bits of CPB cycles, 3 idle cycles between frames).
module tb_fifo_uart_tx;

  localparam int CPB       = 4;
  localparam int CW        = 2;
  localparam int FRAME_LEN = 10 * CPB;
  localparam int PERIOD    = FRAME_LEN + 3;
  localparam int LEAD      = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] frames_sent;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_bytes[8];
  int         over_reads = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .frames_sent(frames_sent)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at sample s (s=0 is the POP cycle of the first byte).
  function automatic logic exp_tx(input int s, input int n);
    int k, i, w, b;
    logic [7:0] byte_v;
    if (s < LEAD) return 1'b1;
    k = s - LEAD;
    i = k / PERIOD;
    w = k % PERIOD;
    if (i < n && w < FRAME_LEN) begin
      b = w / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      byte_v = exp_bytes[i];
      return byte_v[b-1];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_rd(input int s, input int n);
    return (s % PERIOD == 0) && (s / PERIOD < n);
  endfunction

  function automatic logic exp_fd(input int s, input int n);
    int k;
    k = s - LEAD;
    if (k < 0) return 1'b0;
    return (k % PERIOD == FRAME_LEN - 1) && (k / PERIOD < n);
  endfunction

  function automatic logic exp_busy(input int s, input int n);
    int k, i, w;
    if (s < LEAD) return 1'b1;
    k = s - LEAD;
    i = k / PERIOD;
    w = k % PERIOD;
    if (i >= n) return 1'b0;
    if (w < FRAME_LEN) return 1'b1;
    if (w == FRAME_LEN) return 1'b0;
    return (i < n - 1);
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int s, input int n, input int start);
    int c;
    c = start;
    for (int i = 0; i < n; i++) begin
      if (LEAD + i * PERIOD + FRAME_LEN - 1 < s) c++;
    end
    return CW'(c % (1 << CW));
  endfunction

  // Caller is at a negedge. Loads n bytes into the FIFO and compares every
  // following cycle against the frame-level model.
  task automatic run_scn(input string tag, input int n, input int nsamples, input int start_cnt,
                         output int rd_cnt, output int fd_cnt);
    int m_tx, m_rd, m_fd, m_busy, m_cnt;
    int f_tx, f_rd, f_fd, f_busy, f_cnt;
    m_tx = 0; m_rd = 0; m_fd = 0; m_busy = 0; m_cnt = 0;
    f_tx = -1; f_rd = -1; f_fd = -1; f_busy = -1; f_cnt = -1;
    rd_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < n; i++) fifo_q.push_back(exp_bytes[i]);
    fifo_empty = (fifo_q.size() == 0);
    for (int s = 0; s < nsamples; s++) begin
      @(negedge clk);
      if (tx !== exp_tx(s, n)) begin m_tx++; if (f_tx < 0) f_tx = s; end
      if (fifo_rd_en !== exp_rd(s, n)) begin m_rd++; if (f_rd < 0) f_rd = s; end
      if (frame_done !== exp_fd(s, n)) begin m_fd++; if (f_fd < 0) f_fd = s; end
      if (busy !== exp_busy(s, n)) begin m_busy++; if (f_busy < 0) f_busy = s; end
      if (frames_sent !== exp_cnt(s, n, start_cnt)) begin m_cnt++; if (f_cnt < 0) f_cnt = s; end
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (fifo_rd_en === 1'b1) begin
        if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        else over_reads++;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    check($sformatf("%s tx trace mismatches (first sample %0d)", tag, f_tx), m_tx, 0);
    check($sformatf("%s rd_en trace mismatches (first sample %0d)", tag, f_rd), m_rd, 0);
    check($sformatf("%s frame_done trace mismatches (first sample %0d)", tag, f_fd), m_fd, 0);
    check($sformatf("%s busy trace mismatches (first sample %0d)", tag, f_busy), m_busy, 0);
    check($sformatf("%s frames_sent trace mismatches (first sample %0d)", tag, f_cnt), m_cnt, 0);
  endtask

  // Asynchronous reset with its immediate effect checked before any edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    #1;
    check({tag, " tx"}, tx, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " rd_en"}, fifo_rd_en, 0);
    check({tag, " frames_sent"}, frames_sent, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rd_cnt, fd_cnt, n, cnt_rd, cnt_low, cnt_busy;
    rst        = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;

    // Power-on reset.
    #2;
    rst = 1'b1;
    #1;
    check("por tx", tx, 1);
    check("por busy", busy, 0);
    check("por rd_en", fifo_rd_en, 0);
    check("por frame_done", frame_done, 0);
    check("por frames_sent", frames_sent, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // FIFO empty throughout: nothing may move.
    cnt_rd = 0; cnt_low = 0; cnt_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) cnt_rd++;
      if (tx !== 1'b1) cnt_low++;
      if (busy !== 1'b0) cnt_busy++;
    end
    check("empty rd_en cycles", cnt_rd, 0);
    check("empty tx low cycles", cnt_low, 0);
    check("empty busy cycles", cnt_busy, 0);

    // Single byte 0xA5.
    exp_bytes[0] = 8'hA5;
    @(negedge clk);
    run_scn("single", 1, LEAD + PERIOD + 4, 0, rd_cnt, fd_cnt);
    check("single rd pulses", rd_cnt, 1);
    check("single frame_done pulses", fd_cnt, 1);
    check("single frames_sent", frames_sent, 1);

    // Three back-to-back bytes.
    apply_reset("rst_before_three");
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'h55;
    @(negedge clk);
    run_scn("three", 3, LEAD + 3 * PERIOD + 4, 0, rd_cnt, fd_cnt);
    check("three rd pulses", rd_cnt, 3);
    check("three frame_done pulses", fd_cnt, 3);
    check("three frames_sent", frames_sent, 3);

    // Reset during data bit 3 of 0xC3 (line is low there), then send 0x3C.
    exp_bytes[0] = 8'hC3;
    @(negedge clk);
    run_scn("c3_partial", 1, LEAD + 4 * CPB + 2, 3, rd_cnt, fd_cnt);
    check("c3 line low before reset", tx, 0);
    check("c3 frames_sent before reset", frames_sent, 3);
    #1;
    rst = 1'b1;
    #1;
    check("midframe rst tx", tx, 1);
    check("midframe rst busy", busy, 0);
    check("midframe rst rd_en", fifo_rd_en, 0);
    check("midframe rst frames_sent", frames_sent, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_bytes[0] = 8'h3C;
    run_scn("after_rst_3c", 1, LEAD + PERIOD + 6, 0, rd_cnt, fd_cnt);
    check("after_rst rd pulses", rd_cnt, 1);
    check("after_rst frames_sent", frames_sent, 1);

    // Counter wrap: five frames on a 2-bit counter.
    apply_reset("rst_before_wrap");
    for (int i = 0; i < 5; i++) exp_bytes[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    run_scn("wrap", 5, LEAD + 5 * PERIOD + 3, 0, rd_cnt, fd_cnt);
    check("wrap frame_done pulses", fd_cnt, 5);
    check("wrap frames_sent", frames_sent, 1);

    // Random burst.
    apply_reset("rst_before_rand");
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) exp_bytes[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    run_scn("random", n, LEAD + n * PERIOD + 5, 0, rd_cnt, fd_cnt);
    check("random rd pulses", rd_cnt, 32'(n));
    check("random frames_sent", frames_sent, 32'(n % 4));

    check("fifo over-reads", over_reads, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
